// File: rtl/refill_arbiter.sv
// Round-robin refill arbiter: shares one AXI4 read channel between the I-cache and
// D-cache line-refill ports, one INCR burst per line, full line returned with a gnt pulse.
module refill_arbiter #(
  parameter int         OFFSET_LEN = 5,
  parameter logic [3:0] IC_ID      = 4'd0,
  parameter logic [3:0] DC_ID      = 4'd1,
  localparam int        LINE_WORDS = 1 << (OFFSET_LEN - 2),
  localparam int        LINE_W     = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  output logic              ic_gnt,
  output logic              ic_err,
  output logic [LINE_W-1:0] ic_line,
  input  logic              dc_req,
  input  logic [31:0]       dc_addr,
  output logic              dc_gnt,
  output logic              dc_err,
  output logic [LINE_W-1:0] dc_line,
  output logic [31:0]       araddr,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  // Counter runs past LINE_WORDS so over-long bursts are recognised and discarded.
  localparam int CNT_W = IDX_W + 2;
  localparam logic [CNT_W-1:0] LW_C     = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t                          state, state_nxt;
  logic                            owner;       // 0 = I-cache, 1 = D-cache
  logic                            last_owner;
  logic [31:0]                     addr_q;
  logic [CNT_W-1:0]                beat_cnt;
  logic                            err_acc, err_nxt;
  logic [LINE_WORDS-1:0][31:0]     line_buf, buf_nxt;
  logic                            any_req, grant_dc;
  logic [31:0]                     sel_addr;
  logic                            unused_rid;

  assign unused_rid = ^rid;   // single burst outstanding, so rid carries no information
  assign any_req    = ic_req | dc_req;
  // On a tie the port that did not own the previous burst wins.
  assign grant_dc   = dc_req & (~ic_req | ~last_owner);
  assign sel_addr   = grant_dc ? dc_addr : ic_addr;
  assign err_nxt    = err_acc | (rresp != 2'b00) | (rlast & (beat_cnt != LAST_IDX));

  always_comb begin
    buf_nxt = line_buf;
    if (beat_cnt < LW_C) buf_nxt[beat_cnt[IDX_W-1:0]] = rdata;
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    araddr    = '0;
    arid      = '0;
    arlen     = '0;
    arsize    = '0;
    arburst   = '0;
    rready    = 1'b0;
    ic_gnt    = 1'b0;
    dc_gnt    = 1'b0;
    ic_err    = 1'b0;
    dc_err    = 1'b0;
    case (state)
      IDLE: if (any_req) state_nxt = AR;
      AR: begin
        arvalid = 1'b1;
        araddr  = addr_q;
        arid    = owner ? DC_ID : IC_ID;
        arlen   = 8'(LINE_WORDS - 1);
        arsize  = 3'b010;
        arburst = 2'b01;
        if (arready) state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = DONE;
      end
      DONE: begin
        ic_gnt    = ~owner;
        dc_gnt    = owner;
        ic_err    = ~owner & err_acc;
        dc_err    = owner & err_acc;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      addr_q     <= '0;
      beat_cnt   <= '0;
      err_acc    <= 1'b0;
      line_buf   <= '0;
      ic_line    <= '0;
      dc_line    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          owner    <= grant_dc;
          addr_q   <= {sel_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
          beat_cnt <= '0;
          err_acc  <= 1'b0;
        end
        R: if (rvalid) begin
          line_buf <= buf_nxt;
          err_acc  <= err_nxt;
          if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
          // Line registers take the merged buffer so the final beat is included at DONE.
          if (rlast) begin
            if (owner) dc_line <= buf_nxt;
            else       ic_line <= buf_nxt;
          end
        end
        DONE: last_owner <= owner;
        default: ;
      endcase
    end
  end

endmodule
